// File: rtl/ascon_pkg.sv
// Shared ASCON definitions: frame geometry and the result-transmitter state type.
package ascon_pkg;

  localparam int ASCON_CIPHER_W    = 1472;
  localparam int ASCON_TAG_W       = 128;
  localparam int ASCON_FRAME_BYTES = 200;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } tx_state_t;

endpackage

// File: rtl/compteur_Nbits.sv
// Generic N-bit up-counter with synchronous re-initialisation and count enable.
module compteur_Nbits #(
  parameter int N_bits = 8
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              init_i,
  input  logic              en_i,
  output logic [N_bits-1:0] cnt_o
);

  // Count register: init wins over enable.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_o <= {N_bits{1'b0}};
    end else if (init_i) begin
      cnt_o <= {N_bits{1'b0}};
    end else if (en_i) begin
      cnt_o <= cnt_o + N_bits'(1);
    end else begin
      cnt_o <= cnt_o;
    end
  end

endmodule

// File: rtl/ascon_result_tx.sv
// Collects ciphertext and tag from the ASCON controller and streams them out
// MSB-first as a byte-wide valid/ready frame (ciphertext, then tag).
module ascon_result_tx
  import ascon_pkg::*;
#(
  parameter int CIPHER_W = ASCON_CIPHER_W,
  parameter int TAG_W    = ASCON_TAG_W,
  parameter int CNT_W    = 8
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic [CIPHER_W-1:0] cipher_i,
  input  logic [TAG_W-1:0]    tag_i,
  input  logic                en_cipher_reg_i,
  input  logic                en_tag_reg_i,
  output logic [7:0]          byte_o,
  output logic                byte_valid_o,
  input  logic                byte_ready_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                overrun_o
);

  localparam int               FRAME_W     = CIPHER_W + TAG_W;
  localparam int               FRAME_BYTES = FRAME_W / 8;
  localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(FRAME_BYTES - 1);

  tx_state_t           r_state;
  tx_state_t           w_state_nxt;
  logic [CIPHER_W-1:0] r_cipher;
  logic [TAG_W-1:0]    r_tag;
  logic                r_cipher_ok;
  logic                r_tag_ok;
  logic [FRAME_W-1:0]  r_shift;
  logic                r_valid;
  logic                r_done;
  logic                r_overrun;
  logic [CNT_W-1:0]    w_cnt;
  logic                w_accept;
  logic                w_strobe;
  logic                w_complete;
  logic                w_handshake;
  logic                w_last;
  logic [CIPHER_W-1:0] w_cipher_nxt;
  logic [TAG_W-1:0]    w_tag_nxt;

  // IDLE and DONE both accept captures; SEND rejects them.
  assign w_accept     = (r_state != SEND);
  assign w_strobe     = en_cipher_reg_i | en_tag_reg_i;
  assign w_complete   = w_accept & (r_cipher_ok | en_cipher_reg_i) & (r_tag_ok | en_tag_reg_i);
  assign w_handshake  = r_valid & byte_ready_i;
  assign w_last       = w_handshake & (w_cnt == LAST_CNT);
  assign w_cipher_nxt = en_cipher_reg_i ? cipher_i : r_cipher;
  assign w_tag_nxt    = en_tag_reg_i ? tag_i : r_tag;

  compteur_Nbits #(
    .N_bits (CNT_W)
  ) u_byte_cnt (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .init_i  (w_complete),
    .en_i    (w_handshake),
    .cnt_o   (w_cnt)
  );

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_complete) begin
          w_state_nxt = SEND;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SEND: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = SEND;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State plus registered status outputs derived from the next state.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state   <= IDLE;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_valid   <= (w_state_nxt == SEND);
      r_done    <= (w_state_nxt == DONE);
      r_overrun <= r_overrun | (~w_accept & w_strobe);
    end
  end

  // Holding registers and their ready flags; a completed pair clears both flags.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_cipher    <= {CIPHER_W{1'b0}};
      r_tag       <= {TAG_W{1'b0}};
      r_cipher_ok <= 1'b0;
      r_tag_ok    <= 1'b0;
    end else if (w_accept) begin
      r_cipher    <= w_cipher_nxt;
      r_tag       <= w_tag_nxt;
      r_cipher_ok <= w_complete ? 1'b0 : (r_cipher_ok | en_cipher_reg_i);
      r_tag_ok    <= w_complete ? 1'b0 : (r_tag_ok | en_tag_reg_i);
    end else begin
      r_cipher    <= r_cipher;
      r_tag       <= r_tag;
      r_cipher_ok <= r_cipher_ok;
      r_tag_ok    <= r_tag_ok;
    end
  end

  // Frame shift register: the top byte is always the byte on offer.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_shift <= {FRAME_W{1'b0}};
    end else if (w_complete) begin
      r_shift <= {w_cipher_nxt, w_tag_nxt};
    end else if (w_handshake) begin
      r_shift <= {r_shift[FRAME_W-9:0], 8'h00};
    end else begin
      r_shift <= r_shift;
    end
  end

  assign byte_o       = r_shift[FRAME_W-1 -: 8];
  assign byte_valid_o = r_valid;
  assign busy_o       = r_valid;
  assign done_o       = r_done;
  assign overrun_o    = r_overrun;

endmodule

// File: tb/tb_ascon_result_tx.sv
// Scoreboard bench for ascon_result_tx: expected bytes are queued at stimulus
// time and popped by an independent monitor on every accepted byte.
module tb_ascon_result_tx;
  import ascon_pkg::*;

  localparam int CW = ASCON_CIPHER_W;
  localparam int TW = ASCON_TAG_W;
  localparam int NB = ASCON_FRAME_BYTES;
  localparam int CB = CW / 8;

  logic          clock_i = 1'b0;
  logic          reset_i = 1'b0;
  logic [CW-1:0] cipher_i = '0;
  logic [TW-1:0] tag_i = '0;
  logic          en_cipher_reg_i = 1'b0;
  logic          en_tag_reg_i = 1'b0;
  logic          byte_ready_i = 1'b0;
  logic [7:0]    byte_o;
  logic          byte_valid_o, busy_o, done_o, overrun_o;

  ascon_result_tx dut (
    .clock_i         (clock_i),
    .reset_i         (reset_i),
    .cipher_i        (cipher_i),
    .tag_i           (tag_i),
    .en_cipher_reg_i (en_cipher_reg_i),
    .en_tag_reg_i    (en_tag_reg_i),
    .byte_o          (byte_o),
    .byte_valid_o    (byte_valid_o),
    .byte_ready_i    (byte_ready_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .overrun_o       (overrun_o)
  );

  always #5 clock_i = ~clock_i;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int first_valid_cyc = -1;
  int ready_mode = 0;
  logic [7:0] q[$];
  logic [7:0] fr[NB];
  bit prev_stall = 1'b0;
  bit prev_valid = 1'b0;
  logic [7:0] prev_byte = 8'h00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle counter and ready driver: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random.
  initial forever begin
    @(posedge clock_i);
    cyc++;
    #1;
    case (ready_mode)
      0: byte_ready_i = 1'b1;
      1: byte_ready_i = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: byte_ready_i = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: compares every accepted byte with the scoreboard head.
  initial forever begin
    @(negedge clock_i);
    if (reset_i) begin
      if (prev_stall) check("stall_stable", {byte_valid_o, byte_o}, {1'b1, prev_byte});
      if (byte_valid_o && !prev_valid) first_valid_cyc = cyc;
      if (byte_valid_o && byte_ready_i) begin
        hs_cnt++;
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_byte: got %0h expected no byte", byte_o);
        end else begin
          check("stream_byte", byte_o, q.pop_front());
        end
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = byte_valid_o && !byte_ready_i;
      prev_byte  = byte_o;
      prev_valid = byte_valid_o;
    end else begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end
  end

  // kind 0: ascending cipher + F0..FF tag, 1: random, 2: cipher all AA + random tag
  task automatic make_frame(input int kind);
    for (int i = 0; i < NB; i++) begin
      if (kind == 0) fr[i] = (i < CB) ? 8'(i) : 8'(240 + i - CB);
      else if (kind == 2 && i < CB) fr[i] = 8'hAA;
      else fr[i] = 8'($urandom_range(0, 255));
    end
    for (int i = 0; i < CB; i++) cipher_i[CW-1-8*i -: 8] = fr[i];
    for (int i = 0; i < NB - CB; i++) tag_i[TW-1-8*i -: 8] = fr[CB+i];
  endtask

  task automatic push_frame();
    for (int i = 0; i < NB; i++) q.push_back(fr[i]);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock_i);
      #2;
    end
  endtask

  task automatic strobe(input bit c, input bit t, output int t0);
    en_cipher_reg_i = c;
    en_tag_reg_i    = t;
    t0 = cyc;
    tick(1);
    en_cipher_reg_i = 1'b0;
    en_tag_reg_i    = 1'b0;
  endtask

  task automatic clear_stats();
    hs_cnt = 0;
    done_cnt = 0;
    first_valid_cyc = -1;
  endtask

  task automatic wait_done(input int budget);
    int start;
    start = done_cnt;
    for (int k = 0; k < budget && done_cnt == start; k++) tick(1);
    check("done_seen", done_cnt != start, 1'b1);
  endtask

  task automatic wait_hs(input int target, input int budget);
    for (int k = 0; k < budget && hs_cnt < target; k++) tick(1);
    check("hs_reached", hs_cnt >= target, 1'b1);
  endtask

  task automatic frame_end_checks(input string tagname);
    tick(2);
    check({tagname, "_handshakes"}, hs_cnt, NB);
    check({tagname, "_queue_empty"}, q.size(), 0);
    check({tagname, "_done_pulses"}, done_cnt, 1);
    check({tagname, "_busy_after"}, busy_o, 1'b0);
    check({tagname, "_valid_after"}, byte_valid_o, 1'b0);
  endtask

  initial begin
    int t0, t1, dummy, dc;
    #3;
    check("rst_byte", byte_o, 8'h00);
    check("rst_valid", byte_valid_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_overrun", overrun_o, 1'b0);
    tick(2);
    reset_i = 1'b1;
    tick(2);

    // 1: nominal, tag 3 cycles after cipher
    ready_mode = 0;
    make_frame(0);
    clear_stats();
    strobe(1'b1, 1'b0, t0);
    tick(2);
    check("s1_idle_wait", busy_o, 1'b0);
    push_frame();
    strobe(1'b0, 1'b1, t1);
    check("s1_busy", busy_o, 1'b1);
    wait_done(400);
    check("s1_first_valid_lat", first_valid_cyc - t1, 1);
    check("s1_done_lat", done_cyc - t1, 201);
    frame_end_checks("s1");

    // 2: backpressure 1,0,0,1
    ready_mode = 1;
    make_frame(1);
    clear_stats();
    push_frame();
    strobe(1'b1, 1'b1, t0);
    wait_done(1200);
    frame_end_checks("s2");

    // 3a: tag first, cipher 5 cycles later
    ready_mode = 0;
    make_frame(0);
    clear_stats();
    strobe(1'b0, 1'b1, t0);
    tick(4);
    check("s3_tag_only_idle", busy_o, 1'b0);
    push_frame();
    strobe(1'b1, 1'b0, t1);
    wait_done(400);
    check("s3a_first_valid_lat", first_valid_cyc - t1, 1);
    frame_end_checks("s3a");

    // 3b: simultaneous strobes
    clear_stats();
    push_frame();
    strobe(1'b1, 1'b1, t1);
    wait_done(400);
    check("s3b_first_valid_lat", first_valid_cyc - t1, 1);
    check("s3b_done_lat", done_cyc - t1, 201);
    frame_end_checks("s3b");

    // 4: overrun at byte 50, random backpressure
    ready_mode = 2;
    make_frame(1);
    clear_stats();
    push_frame();
    strobe(1'b1, 1'b1, t0);
    wait_hs(50, 400);
    cipher_i = {CB{8'hAA}};
    strobe(1'b1, 1'b0, dummy);
    check("s4_overrun_set", overrun_o, 1'b1);
    wait_done(1200);
    frame_end_checks("s4");
    check("s4_overrun_sticky", overrun_o, 1'b1);
    make_frame(2);
    clear_stats();
    push_frame();
    strobe(1'b1, 1'b1, t0);
    wait_done(1200);
    frame_end_checks("s4_next");
    check("s4_overrun_still", overrun_o, 1'b1);

    // 5: reset at byte 100
    ready_mode = 0;
    make_frame(1);
    clear_stats();
    push_frame();
    strobe(1'b1, 1'b1, t0);
    wait_hs(100, 400);
    #1;
    reset_i = 1'b0;
    #1;
    check("s5_rst_valid", byte_valid_o, 1'b0);
    check("s5_rst_busy", busy_o, 1'b0);
    check("s5_rst_overrun", overrun_o, 1'b0);
    q.delete();
    dc = done_cnt;
    tick(3);
    check("s5_no_done", done_cnt, dc);
    reset_i = 1'b1;
    tick(2);
    make_frame(1);
    clear_stats();
    push_frame();
    strobe(1'b1, 1'b1, t1);
    wait_done(400);
    check("s5_first_valid_lat", first_valid_cyc - t1, 1);
    check("s5_done_lat", done_cyc - t1, 201);
    frame_end_checks("s5");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ascon_result_tx.md
Name: ascon_result_tx

Overview:
- Downstream stage of the ASCON encryption controller. Consumes the 1472-bit ciphertext and the 128-bit tag when the controller pulses its capture enables.
- Serialises the pair into a 200-byte stream over a valid/ready byte interface. The stream feeds the board UART transmitter, which is how ciphertext and tag leave the FPGA.
- Byte order: ciphertext first, then tag; MSB-first within each field.

Parameters:
- CIPHER_W, 1472, ciphertext width in bits; multiple of 8.
- TAG_W, 128, tag width in bits; multiple of 8.
- CNT_W, 8, byte-counter width; must satisfy 2**CNT_W > (CIPHER_W+TAG_W)/8.

Ports:
- clock_i  in  1  system clock; single clock domain.
- reset_i  in  1  asynchronous, active-low reset.
- cipher_i  in  CIPHER_W  ciphertext from the controller.
- tag_i  in  TAG_W  tag from the controller.
- en_cipher_reg_i  in  1  capture strobe for cipher_i.
- en_tag_reg_i  in  1  capture strobe for tag_i.
- byte_o  out  8  current stream byte.
- byte_valid_o  out  1  byte_o holds a valid byte.
- byte_ready_i  in  1  sink accepts byte_o this cycle.
- busy_o  out  1  high in SEND.
- done_o  out  1  one-cycle pulse after the last byte is accepted.
- overrun_o  out  1  sticky flag: a capture strobe arrived while in SEND.

Behaviour:
- Reset (asynchronous, reset_i=0):
  - state=IDLE, cipher_ok=0, tag_ok=0, shift register=0, counter=0.
  - byte_o=0, byte_valid_o=0, busy_o=0, done_o=0, overrun_o=0.
  - A reset mid-transfer aborts it; no partial resume.
- States: IDLE, SEND, DONE.
- IDLE:
  - A strobe sets the matching holding register and its _ok flag. Strobes are level-sampled on the clock edge and may hold high for several cycles; the value is re-captured each cycle the strobe is high.
  - Both strobes in the same cycle: capture both.
  - On the edge where both flags are, or become, set: load shift reg = {cipher, tag} (1600 bits), counter=0, clear both flags, go to SEND.
  - Tag arriving without a prior cipher: hold the tag and wait for the cipher; this is legal.
- SEND:
  - byte_valid_o=1, byte_o = shift reg [top 8 bits]. First byte is visible in the cycle after the completing strobe edge.
  - Handshake fires when valid && ready. On that edge: shift left by 8, counter+1.
  - byte_o and byte_valid_o stay stable while ready=0. Valid never drops mid-stream.
  - When the handshake occurs with counter == 199: go to DONE; valid drops on that edge.
  - Strobes in SEND are ignored (holding regs unchanged) and set overrun_o. overrun_o clears only on reset.
- DONE:
  - done_o=1 for exactly one cycle, then IDLE.
  - Strobes in DONE are captured as in IDLE.
- Throughput: 1 byte/cycle with ready held high. With ready=1 throughout, the minimum time from completing strobe to done_o is 201 cycles.
- Counter: unsigned CNT_W bits, no wrap possible within one frame.

Decomposition:
- Add to shared package ascon_pkg:
  - constants ASCON_CIPHER_W=1472, ASCON_TAG_W=128, ASCON_FRAME_BYTES=200;
  - typedef enum tx_state_t {IDLE, SEND, DONE}.
- Byte counter: reuse compteur_Nbits with N_bits=CNT_W (en = handshake, init = load). No new sub-module. The shift register lives in this block.

Test Plan:
1. Nominal: cipher = bytes 0x00..0xB7 ascending, tag = 0xF0..0xFF. Strobe en_cipher, then en_tag 3 cycles later, ready=1 throughout. Expect:
   - 200 bytes in order 0x00..0xB7 then 0xF0..0xFF;
   - first valid one cycle after the tag strobe;
   - done_o one pulse, 201 cycles after the tag strobe;
   - busy_o low afterwards.
2. Backpressure: same data, ready toggled 1,0,0,1 repeating. Expect:
   - byte_o stable during every ready=0 cycle;
   - no byte skipped or duplicated;
   - exactly 200 handshakes.
3. Tag-before-cipher, then simultaneous strobes:
   - tag first, cipher 5 cycles later: transfer starts the cycle after the cipher strobe;
   - separate frame with both strobes in the same cycle: starts the next cycle.
   - Byte order identical to scenario 1 in both cases.
4. Overrun: strobe en_cipher with cipher=all 0xAA at byte 50 of a transfer. Expect:
   - overrun_o=1 and stays 1;
   - remaining bytes unchanged from the original frame;
   - the next frame, after a fresh strobe pair, transmits the new data.
5. Reset mid-operation: assert reset_i=0 at byte 100. Expect:
   - byte_valid_o=0, busy_o=0, overrun_o=0 immediately (asynchronous);
   - no done_o;
   - after release, a new strobe pair yields a full 200-byte frame from byte 0.
